// File: rtl/mux_truth_table_scanner_if.sv
// mux_truth_table_scanner_if: stimulus/capture bundle between the scanner and its function under test
interface mux_truth_table_scanner_if #(parameter int N_INPUTS = 3);
  logic                       start;
  logic                       y_in;
  logic [N_INPUTS-1:0]        drv;
  logic                       busy;
  logic                       done;
  logic [(1<<N_INPUTS)-1:0]   minterms;
  logic [N_INPUTS:0]          mismatch_count;
  logic                       pass;
  modport master (output start, y_in, input drv, busy, done, minterms, mismatch_count, pass);
  modport slave  (input start, y_in, output drv, busy, done, minterms, mismatch_count, pass);
endinterface

// File: rtl/mux_truth_table_scanner.sv
// mux_truth_table_scanner: walks every input combination, captures y_in per vector and counts mismatches
module mux_truth_table_scanner #(
  parameter int                        N_INPUTS      = 3,
  parameter int                        SETTLE_CYCLES = 1,
  parameter logic [(1<<N_INPUTS)-1:0]  EXPECTED      = 8'h04
) (
  input  logic                               clk,
  input  logic                               rst_n,
  mux_truth_table_scanner_if.slave           bus
);
  localparam int V  = 1 << N_INPUTS;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  state_t              r_state;
  logic [N_INPUTS-1:0] r_idx;
  logic [CW-1:0]       r_cnt;
  logic [N_INPUTS-1:0] r_drv;
  logic                r_busy;
  logic                r_done;
  logic [V-1:0]        r_minterms;
  logic [N_INPUTS:0]   r_mc;
  logic                r_pass;
  logic                w_miss;
  logic [N_INPUTS:0]   w_mc_next;
  assign w_miss    = bus.y_in != EXPECTED[r_idx];
  assign w_mc_next = r_mc + {{N_INPUTS{1'b0}}, w_miss};
  assign bus.drv            = r_drv;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.minterms       = r_minterms;
  assign bus.mismatch_count = r_mc;
  assign bus.pass           = r_pass;
  // scan FSM; pass is taken from the post-sample count so it is valid alongside done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_drv      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_minterms <= '0;
      r_mc       <= '0;
      r_pass     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_idx      <= '0;
          r_drv      <= '0;
          r_minterms <= '0;
          r_mc       <= '0;
          r_busy     <= 1'b1;
          r_cnt      <= CW'(SETTLE_CYCLES);
          r_state    <= SETTLE;
        end
        SETTLE: if (r_cnt == CW'(1)) r_state <= SAMPLE;
                else r_cnt <= r_cnt - CW'(1);
        SAMPLE: begin
          r_minterms[r_idx] <= bus.y_in;
          r_mc              <= w_mc_next;
          if (r_idx == N_INPUTS'(V - 1)) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= w_mc_next == '0;
          end else begin
            r_idx   <= r_idx + N_INPUTS'(1);
            r_drv   <= r_idx + N_INPUTS'(1);
            r_cnt   <= CW'(SETTLE_CYCLES);
            r_state <= SETTLE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_pass  <= r_mc == '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mux_truth_table_scanner.sv
// tb_mux_truth_table_scanner: randomized truth-table scans checked against a table-level reference model
module tb_mux_truth_table_scanner;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] tbl = 8'h04;
  int         n_checks = 0;
  int         n_errors = 0;
  bit         model_pass = 1'b0;
  always #5 clk = ~clk;
  mux_truth_table_scanner_if #(.N_INPUTS(3)) ifa ();
  mux_truth_table_scanner_if #(.N_INPUTS(3)) ifb ();
  mux_truth_table_scanner #(.N_INPUTS(3), .SETTLE_CYCLES(1), .EXPECTED(8'h04)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  mux_truth_table_scanner #(.N_INPUTS(3), .SETTLE_CYCLES(3), .EXPECTED(8'h04)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  assign ifa.start = start & ~sel;
  assign ifb.start = start & sel;
  assign ifa.y_in  = tbl[ifa.drv];
  assign ifb.y_in  = tbl[ifb.drv];
  logic [2:0] drv_v;
  logic       busy_v, done_v, pass_v;
  logic [7:0] mint_v;
  logic [3:0] mc_v;
  assign drv_v  = sel ? ifb.drv : ifa.drv;
  assign busy_v = sel ? ifb.busy : ifa.busy;
  assign done_v = sel ? ifb.done : ifa.done;
  assign pass_v = sel ? ifb.pass : ifa.pass;
  assign mint_v = sel ? ifb.minterms : ifa.minterms;
  assign mc_v   = sel ? ifb.mismatch_count : ifa.mismatch_count;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_scan(input logic [7:0] t, input int sc, input bit hold);
    int lat = 0;
    int bad_drv = 0;
    int exp_mc;
    tbl = t;
    exp_mc = $countones(t ^ 8'h04);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    chk("accept_busy", 32'(busy_v), 1);
    chk("accept_clear", {20'd0, mc_v, mint_v}, 0);
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (k == 3) chk("pass_hold", 32'(pass_v), 32'(model_pass));
      if (done_v) begin
        lat = k;
        break;
      end
      if (32'(drv_v) != k / (sc + 1) || !busy_v) bad_drv++;
    end
    chk("latency", lat, 8 * (sc + 1));
    chk("drv_seq", bad_drv, 0);
    chk("drv_final", 32'(drv_v), 7);
    chk("busy_done", 32'(busy_v), 0);
    chk("minterms", 32'(mint_v), 32'(t));
    chk("mismatch", 32'(mc_v), exp_mc);
    model_pass = exp_mc == 0;
    @(posedge clk); #1;
    chk("done_pulse", 32'(done_v), 0);
    chk("pass", 32'(pass_v), 32'(model_pass));
  endtask

  initial begin
    int cyc;
    #1;
    chk("rst_outs", {ifa.busy, ifa.done, ifa.pass, ifa.drv, ifa.mismatch_count, ifa.minterms}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_scan(8'h04, 1, 1'b0);
    run_scan(8'hCC, 1, 1'b0);
    run_scan(8'hFF, 1, 1'b0);
    run_scan(8'h04, 1, 1'b0);
    for (int r = 0; r < 6; r++) run_scan(8'($urandom), 1, 1'b0);
    run_scan(8'h04, 1, 1'b1);
    @(posedge clk); #1;
    chk("hold_restart_busy", 32'(busy_v), 1);
    chk("hold_restart_clear", 32'(mint_v), 0);
    start = 1'b0;
    cyc = 0;
    while (!done_v && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("hold_second_done", 32'(done_v), 1);
    @(posedge clk); #1;
    chk("hold_second_pass", 32'(pass_v), 1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (drv_v != 3'd4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_drv4", 32'(drv_v), 4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {busy_v, done_v, pass_v, drv_v, mc_v, mint_v}, 0);
    model_pass = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done_v || busy_v || drv_v != 0) cyc++;
    end
    chk("idle_after_rst", cyc, 0);
    sel = 1'b1;
    run_scan(8'h04, 3, 1'b0);
    run_scan(8'($urandom), 3, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
